// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch stage of the processador core: holds the PC, issues word requests to
// instruction memory (fixed one-cycle read latency), buffers returned words
// with their PCs in a 2-entry FIFO and hands them to decode over valid/ready.
// Execute redirects flush the buffer and discard any stale response.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a redirect to a target with pc[1:0] != 0 queues one marker
//               entry (pc = raw target, instr = NOP, misalign = 1) and halts
//               fetching until the next redirect.
//   undefined : target low bits are ignored, fetching never halts and
//               if_misalign is tied low.
//
// mode      | meaning
// ----------+------------------------------------------------------------
// MODE_RUN  | normal fetching, requests issued whenever buffer credit allows
// MODE_HALT | misaligned target seen; no requests until the next redirect
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misalign
);

  localparam logic [0:0]  MODE_RUN   = 1'b0;
  localparam logic [31:0] RESET_PC_A = {RESET_PC[31:2], 2'b00};

  logic [0:0]  mode;
  logic [31:0] fetch_pc;
  logic [31:0] tag_pc;
  logic        inflight;
  logic        drop;

  logic [31:0] pc_q    [2];
  logic [31:0] instr_q [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        pop;
  logic        accept;
  logic        rsp_take;
  logic        push;
  logic [31:0] push_pc;
  logic [31:0] push_instr;
  logic [1:0]  credit_used;
  logic        credit_ok;
  logic [31:0] target_pc;

  assign target_pc = {redirect_pc[31:2], 2'b00};

  assign if_valid = (count != 2'd0);
  assign if_pc    = pc_q[rd_ptr];
  assign if_instr = instr_q[rd_ptr];
  assign pop      = if_valid & if_ready;

  // A slot is owned either by a buffered entry or by the request in flight;
  // a slot freed by this cycle's pop may be reused immediately.
  assign credit_used = count + {1'b0, inflight};
  assign credit_ok   = (credit_used < 2'd2) | ((credit_used == 2'd2) & pop);

  // rst_n gating keeps the request low while reset is held and lets the
  // first request go out in the very first cycle after release.
  assign imem_req_valid = rst_n & (mode == MODE_RUN) & ~redirect_valid & credit_ok;
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid & imem_req_ready;
  assign rsp_take       = inflight & imem_rsp_valid;

`ifdef FETCH_MISALIGN_CHK_EN
  localparam logic [0:0]  MODE_HALT = 1'b1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        mis_pend;
  logic [31:0] mis_pc;
  logic [1:0]  mis_q;
  logic        target_misaligned;

  assign target_misaligned = (redirect_pc[1:0] != 2'b00);

  // After a redirect no request is outstanding except a dropped one, so the
  // marker push never collides with a real response push.
  assign push       = ~redirect_valid & (mis_pend | (rsp_take & ~drop));
  assign push_pc    = mis_pend ? mis_pc : tag_pc;
  assign push_instr = mis_pend ? NOP_INSTR : imem_rsp_data;
  assign if_misalign = mis_q[rd_ptr];

  // Mode and pending-marker tracking; any redirect re-evaluates both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode     <= MODE_RUN;
      mis_pend <= 1'b0;
      mis_pc   <= '0;
    end else if (redirect_valid) begin
      mode     <= target_misaligned ? MODE_HALT : MODE_RUN;
      mis_pend <= target_misaligned;
      mis_pc   <= redirect_pc;
    end else begin
      mis_pend <= 1'b0;
    end
  end

  // Misalign flag storage, written alongside the FIFO entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_q <= 2'b00;
    end else if (!redirect_valid && push) begin
      mis_q[wr_ptr] <= mis_pend;
    end
  end
`else
  logic [1:0] unused_redirect_lsb;

  assign unused_redirect_lsb = redirect_pc[1:0];
  assign mode        = MODE_RUN;
  assign push        = rsp_take & ~drop & ~redirect_valid;
  assign push_pc     = tag_pc;
  assign push_instr  = imem_rsp_data;
  assign if_misalign = 1'b0;
`endif

  // PC, outstanding-request and stale-response tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC_A;
      tag_pc   <= '0;
      inflight <= 1'b0;
      drop     <= 1'b0;
    end else if (redirect_valid) begin
      fetch_pc <= target_pc;
      // A response landing in the redirect cycle is discarded outright; only
      // a request still unanswered afterwards needs the drop flag.
      inflight <= inflight & ~imem_rsp_valid;
      drop     <= inflight & ~imem_rsp_valid;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
        tag_pc   <= fetch_pc;
      end
      if (accept) begin
        inflight <= 1'b1;
      end else if (rsp_take) begin
        inflight <= 1'b0;
      end
      if (rsp_take) begin
        drop <= 1'b0;
      end
    end
  end

  // Two-entry fetch buffer; a redirect empties it and swallows any pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]    <= push_pc;
        instr_q[wr_ptr] <= push_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding decode inside the `processador` RISC-V core. Holds the PC, issues word requests to instruction memory (fixed one-cycle read latency), buffers returned instructions with their PCs in a 2-entry FIFO, and presents them to decode over a valid/ready handshake. Accepts branch/jump redirects from execute and discards stale fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_addr`  out  32  word address, bits [1:0] always 00.
- `imem_req_ready`  in  1  memory accepts request this cycle.
- `imem_rsp_valid`  in  1  read data valid; asserted exactly one cycle after each accept.
- `imem_rsp_data`  in  32  instruction word.
- `redirect_valid`  in  1  execute requests PC change.
- `redirect_pc`  in  32  redirect target.
- `if_valid`  out  1  FIFO head valid.
- `if_ready`  in  1  decode consumes head.
- `if_pc`  out  32  PC of head.
- `if_instr`  out  32  instruction of head.
- `if_misalign`  out  1  head is a misaligned-target marker (see Configuration).

## Operation
- State: `fetch_pc`, `inflight` (0/1), `drop` flag, FIFO `count` (0..2), mode RUN/HALT.
- Request: `imem_req_valid` = RUN and no redirect this cycle and (`count + inflight < 2`, or `== 2` with a pop this cycle). `imem_req_addr` = `fetch_pc`.
- Accept (`imem_req_valid & imem_req_ready`): `fetch_pc += 4` (wraps mod 2^32), `inflight <= 1`, accepted PC latched for tagging.
- Response: when `inflight` and `imem_rsp_valid`: if `drop`, discard and clear `drop`; else push {pc, data, misalign=0}. `imem_rsp_valid` with `inflight=0` is ignored.
- Pop: `if_valid & if_ready` removes head. Push and pop in same cycle allowed at any count.
- Redirect (highest priority): FIFO cleared; any pop in that cycle discarded; `fetch_pc <= {redirect_pc[31:2],2'b00}`; if a request is accepted-but-unanswered, `drop <= 1`; no request issued that cycle; mode returns to RUN.
- Request addr/valid held stable while `imem_req_ready` low, unless redirect.

## Timing
- Reset values: `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `if_valid=0`, `if_pc=0`, `if_instr=0`, `if_misalign=0`; `count=0`, `inflight=0`, `drop=0`, mode RUN.
- First request in the first cycle after `rst_n` deasserts.
- Latency: accept at cycle t -> response t+1 -> `if_valid` at t+2 (no bypass).
- Sustained throughput 1 instruction/cycle with `imem_req_ready=1` and `if_ready=1`.
- Combinational path `if_ready` -> `imem_req_valid` exists (credit reuse); no path from `imem_rsp_*` to outputs.
- Redirect at cycle t: first request for target at t+1, earliest `if_valid` for it at t+3.
- FIFO never overflows: credit check guarantees push only when slot free.
- Async reset mid-operation: all state cleared immediately; a response arriving after reset is ignored.

## Configuration
- `FETCH_MISALIGN_CHK_EN` defined: redirect with `redirect_pc[1:0] != 0` pushes one entry {pc=redirect_pc, instr=32'h0000_0013, misalign=1} in the cycle after the redirect, enters HALT (no requests) until the next redirect.
- Not defined: `redirect_pc[1:0]` ignored (forced 00), HALT unreachable, `if_misalign` tied 0.

## Test plan
- Reset + stream: RESET_PC=0, memory returns addr^32'hA5A5_0000, `if_ready=1` -> `if_pc` 0,4,8,... each cycle from cycle 2, data matches.
- Backpressure: `if_ready=0` 5 cycles -> `count` reaches 2, `imem_req_valid` low, on release PCs continue in order with no gap or duplicate.
- Redirect with fetch in flight: redirect to 0x100 in cycle 0x8 is accepted -> 0x8 response dropped, next `if_pc`=0x100, then 0x104.
- Memory stall: `imem_req_ready=0` 3 cycles at addr 0xC -> addr held 0xC, `fetch_pc` unchanged, resumes with 0xC.
- Misalign (macro on): redirect 0x102 -> single entry pc=0x102, instr=0x13, `if_misalign=1`, no requests until redirect 0x200; macro off -> fetches 0x100.
- Reset mid-run with `count=2`, inflight=1 -> `if_valid`=0 immediately, post-reset stray `imem_rsp_valid` ignored, fetch restarts at RESET_PC.
